// File: rtl/rns_to_binary_m129_pkg.sv
//----------------------------------------------------------------------------
// Module   : rns129_pkg
// Purpose  : Shared constants and width helpers for the mod-(2^N+1) residue path.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package rns129_pkg;

    localparam int N_DEFAULT = 7;

    // High modulus 2^n+1.
    function automatic int m_hi(input int n);
        return (1 << n) + 1;
    endfunction

    // Width of a reconstructed value in 0 .. 2^n*(2^n+1)-1.
    function automatic int x_width(input int n);
        return 2 * n + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rns_to_binary_m129_mod_sub_m.sv
//----------------------------------------------------------------------------
// Module   : mod_sub_m
// Purpose  : Combinational (a - b) mod (2^N+1) using one conditional subtract.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module mod_sub_m
    import rns129_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N:0] a,
    input  logic [N:0] b,
    output logic [N:0] y
);

    localparam logic [N+1:0] c_M = (N+2)'(m_hi(N));

    logic [N+1:0] w_d;

    // Adding M first keeps the difference non-negative for legal operands.
    assign w_d = {1'b0, a} + c_M - {1'b0, b};
    assign y   = (N+1)'((w_d >= c_M) ? (w_d - c_M) : w_d);

endmodule

`default_nettype wire

// File: rtl/rns_to_binary_m129.sv
//----------------------------------------------------------------------------
// Module   : rns_to_binary_m129
// Purpose  : 2-stage valid/ready reverse converter (X mod 2^N, X mod 2^N+1) -> X.
//            Optional macro RANGE_CHECK_EN flags r_hi > 2^N and zeroes out_x.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module rns_to_binary_m129
    import rns129_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_r_lo,
    input  logic [N:0]   in_r_hi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2*N:0] out_x,
    output logic         out_err
);

    localparam int c_XW = x_width(N);

    logic            w_s1_ready;
    logic            w_s2_ready;
    logic [N:0]      w_k;
    logic [c_XW-1:0] w_x_next;

    logic            r_s1_valid;
    logic [N-1:0]    r_s1_lo;
    logic [N:0]      r_s1_k;
    logic            r_s2_valid;
    logic [c_XW-1:0] r_s2_x;

    assign w_s2_ready = !r_s2_valid || out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign in_ready   = w_s1_ready;

    mod_sub_m #(
        .N (N)
    ) u_mod_sub (
        .a ({1'b0, in_r_lo}),
        .b (in_r_hi),
        .y (w_k)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_lo    <= '0;
            r_s1_k     <= '0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_lo <= in_r_lo;
                r_s1_k  <= w_k;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_x     <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_x <= w_x_next;
            end
        end
    end

`ifdef RANGE_CHECK_EN
    localparam logic [N:0] c_R_HI_MAX = {1'b1, {N{1'b0}}};

    logic r_s1_err;
    logic r_s2_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_err <= 1'b0;
        end else if (w_s1_ready && in_valid) begin
            r_s1_err <= (in_r_hi > c_R_HI_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_err <= 1'b0;
        end else if (w_s2_ready && r_s1_valid) begin
            r_s2_err <= r_s1_err;
        end
    end

    assign w_x_next = r_s1_err ? '0 : {r_s1_k, r_s1_lo};
    assign out_err  = r_s2_err;
`else
    // r_lo < 2^N, so r_lo + (k << N) is a plain concatenation with no carry.
    assign w_x_next = {r_s1_k, r_s1_lo};
    assign out_err  = 1'b0;
`endif

    assign out_valid = r_s2_valid;
    assign out_x     = r_s2_x;

endmodule

`default_nettype wire

// File: tb/tb_rns_to_binary_m129.sv
//----------------------------------------------------------------------------
// Module   : tb_rns_to_binary_m129
// Purpose  : Scoreboard bench for the mod-129 reverse converter (N=7).
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_rns_to_binary_m129;

    localparam int N     = 7;
    localparam int X_MAX = 128 * 129 - 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_r_lo;
    logic [N:0]    in_r_hi;
    logic          out_valid;
    logic          out_ready;
    logic [2*N:0]  out_x;
    logic          out_err;

    int            n_vec;
    int            n_err;
    bit            bp_mode;
    logic [2*N:0]  drv_x;
    logic          drv_err;
    logic [2*N:0]  exp_x[$];
    logic          exp_e[$];

    rns_to_binary_m129 #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r_lo   (in_r_lo),
        .in_r_hi   (in_r_hi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_err   (out_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference CRT by search: the unique X in range with both residues.
    function automatic int crt_ref(input int lo, input int hi);
        for (int x = 0; x <= X_MAX; x++) begin
            if ((x % 128) == lo && (x % 129) == hi) return x;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic monitor();
        logic         prev_stall = 1'b0;
        logic [2*N:0] prev_x     = '0;
        logic         prev_err   = 1'b0;
        logic         rdy_exp;
        logic [2*N:0] hx;
        logic         he;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_x.delete();
                exp_e.delete();
                prev_stall = 1'b0;
            end else begin
                rdy_exp = !(exp_x.size() == 2 && !out_ready);
                n_vec++;
                if (in_ready !== rdy_exp) begin
                    n_err++;
                    $display("FAIL in_ready: got %b want %b (inflight=%0d)", in_ready, rdy_exp, exp_x.size());
                end
                if (prev_stall) begin
                    n_vec++;
                    if (out_valid !== 1'b1 || out_x !== prev_x || out_err !== prev_err) begin
                        n_err++;
                        $display("FAIL stall_hold: got v=%b x=%0d e=%b want v=1 x=%0d e=%b",
                                 out_valid, out_x, out_err, prev_x, prev_err);
                    end
                end
                if (out_valid === 1'b1 && exp_x.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_out: got out_valid=1 x=%0d want no output", out_x);
                end else if (out_valid === 1'b1 && out_ready) begin
                    hx = exp_x.pop_front();
                    he = exp_e.pop_front();
                    n_vec++;
                    if (out_x !== hx || out_err !== he) begin
                        n_err++;
                        $display("FAIL result: got x=%0d err=%b want x=%0d err=%b", out_x, out_err, hx, he);
                    end
                end
                if (in_valid && in_ready) begin
                    exp_x.push_back(drv_x);
                    exp_e.push_back(drv_err);
                end
                prev_stall = out_valid && !out_ready;
                prev_x     = out_x;
                prev_err   = out_err;
            end
        end
    endtask

    task automatic send(input int lo, input int hi, input int x, input bit err);
        logic acc;
        int   waits;
        in_valid = 1'b1;
        in_r_lo  = N'(lo);
        in_r_hi  = (N+1)'(hi);
        drv_x    = (2*N+1)'(x);
        drv_err  = err;
        waits    = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) break;
            waits++;
            if (waits > 100) begin
                n_vec++;
                n_err++;
                $display("FAIL send_timeout: got in_ready=0 for 100 cycles want accept");
                break;
            end
        end
        in_valid = 1'b0;
        in_r_lo  = N'($urandom);
        in_r_hi  = (N+1)'($urandom);
    endtask

    task automatic drain();
        int waits = 0;
        bp_mode   = 1'b0;
        out_ready = 1'b1;
        while (exp_x.size() > 0 && waits < 50) begin
            tick();
            waits++;
        end
        n_vec++;
        if (exp_x.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d outstanding want 0", exp_x.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || out_x !== '0 || out_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b x=%0d e=%b want 0 0 0", out_valid, out_x, out_err);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tick();
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_r_lo   = 7'd57;
        in_r_hi   = 8'd90;
        drv_x     = 15'd12345;
        drv_err   = 1'b0;
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: got out_valid=%b want 0", out_valid);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || out_x !== 15'd12345 || out_err !== 1'b0) begin
            n_err++;
            $display("FAIL latency_result: got v=%b x=%0d e=%b want v=1 x=12345 e=0", out_valid, out_x, out_err);
        end
        tick();
        drain();
    endtask

    task automatic test_extremes();
        int lo_t[5] = '{0, 127, 1, 0, 5};
        int hi_t[5] = '{0, 128, 1, 128, 5};
        for (int i = 0; i < 5; i++) send(lo_t[i], hi_t[i], crt_ref(lo_t[i], hi_t[i]), 1'b0);
        drain();
    endtask

    task automatic test_stream();
        int x;
        bp_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            x = $urandom_range(0, X_MAX);
            send(x % 128, x % 129, x, 1'b0);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        send(10, 10, 10, 1'b0);
        send(20, 20, 20, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got out_valid=%b want 0", out_valid);
        end
        tick();
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_stale: got out_valid=%b x=%0d want 0", out_valid, out_x);
            end
            tick();
        end
        send(5, 5, 5, 1'b0);
        drain();
    endtask

    task automatic test_range();
        send(1, 1, 1, 1'b0);
`ifdef RANGE_CHECK_EN
        send(3, 200, 0, 1'b1);
`else
        // d = 3+129-200 wraps to 444 in 9 bits, minus 129 = 315, k keeps 8 bits = 59.
        send(3, 200, 59 * 128 + 3, 1'b0);
`endif
        send(2, 2, 2, 1'b0);
        drain();
    endtask

    task automatic test_exhaustive();
        bp_mode   = 1'b0;
        out_ready = 1'b1;
        for (int x = 0; x <= X_MAX; x++) send(x % 128, x % 129, x, 1'b0);
        drain();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        bp_mode   = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_r_lo   = '0;
        in_r_hi   = '0;
        out_ready = 1'b1;
        drv_x     = '0;
        drv_err   = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_latency();
        test_extremes();
        test_stream();
        test_reset_midflight();
        test_range();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
